// File: rtl/adder_2_inv_pkg.sv
// Width defaults shared by the forward 4-operand adder and its inverse,
// so both ends of the link agree on the data and counter widths.
package adder_2_inv_pkg;

  localparam int DSIZE_DEF = 64;
  localparam int UF_W_DEF  = 16;

endpackage

// File: rtl/adder_2_inv_pipe_stage_hs.sv
// One valid/enable pipeline register. Data only loads with a valid beat,
// so an enabled-but-empty stage clears its valid and keeps stale data.
module pipe_stage_hs
  import adder_2_inv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         vld_in,
  input  logic [W-1:0] d_in,
  output logic         vld_out,
  output logic [W-1:0] d_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out <= 1'b0;
      d_out   <= '0;
    end else if (en) begin
      vld_out <= vld_in;
      if (vld_in) d_out <= d_in;
    end
  end

endmodule

// File: rtl/adder_2_inv.sv
// Inverse of the 4-operand adder: recovers the fourth operand as
// sum - a - b - c through a two-stage valid/ready pipeline.
module adder_2_inv
  import adder_2_inv_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int UF_W  = UF_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DSIZE-1:0] sum,
  input  logic [DSIZE-1:0] in_a,
  input  logic [DSIZE-1:0] in_b,
  input  logic [DSIZE-1:0] in_c,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DSIZE-1:0] diff,
  output logic             borrow,
  input  logic             uf_clr,
  output logic [UF_W-1:0]  uf_cnt
);

  localparam int XW = DSIZE + 2;

  function automatic logic [UF_W-1:0] sat_inc(input logic [UF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic          s1_en, s2_en;
  logic          vld_p1, vld_p2;
  logic [XW-1:0] sum_x_p0, partial_p0;
  logic [XW-1:0] sum_x_p1, partial_p1;
  logic [DSIZE-1:0] diff_p1;
  logic             borrow_p1;
  logic [DSIZE:0]   res_p2;

  assign s2_en  = ~vld_p2 | out_rdy;
  assign s1_en  = ~vld_p1 | s2_en;
  assign in_rdy = s1_en;

  // ---- S0 -> S1: exact 3-way partial sum, two guard bits so it never wraps
  assign sum_x_p0   = {2'b00, sum};
  assign partial_p0 = {2'b00, in_a} + {2'b00, in_b} + {2'b00, in_c};

  pipe_stage_hs #(.W(2 * XW)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (s1_en),
    .vld_in  (in_vld),
    .d_in    ({sum_x_p0, partial_p0}),
    .vld_out (vld_p1),
    .d_out   ({sum_x_p1, partial_p1})
  );

  // ---- S1 -> S2: modular difference plus borrow from the exact compare
  assign diff_p1   = sum_x_p1[DSIZE-1:0] - partial_p1[DSIZE-1:0];
  assign borrow_p1 = (partial_p1 > sum_x_p1);

  pipe_stage_hs #(.W(DSIZE + 1)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (s2_en),
    .vld_in  (vld_p1),
    .d_in    ({borrow_p1, diff_p1}),
    .vld_out (vld_p2),
    .d_out   (res_p2)
  );

  assign out_vld = vld_p2;
  assign diff    = res_p2[DSIZE-1:0];
  assign borrow  = res_p2[DSIZE];

  // ---- Underflow counter: clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_cnt <= '0;
    end else if (uf_clr) begin
      uf_cnt <= '0;
    end else if (vld_p2 && out_rdy && borrow) begin
      uf_cnt <= sat_inc(uf_cnt);
    end
  end

endmodule

// File: tb/tb_adder_2_inv.sv
// Scoreboard bench for adder_2_inv at DSIZE=8, UF_W=4 with directed vectors.
module tb_adder_2_inv;

  localparam int DW = 8;
  localparam int UW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] sum = '0, in_a = '0, in_b = '0, in_c = '0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [DW-1:0] diff;
  logic          borrow;
  logic          uf_clr = 1'b0;
  logic [UW-1:0] uf_cnt;

  adder_2_inv #(.DSIZE(DW), .UF_W(UW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .sum     (sum),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_c    (in_c),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .diff    (diff),
    .borrow  (borrow),
    .uf_clr  (uf_clr),
    .uf_cnt  (uf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   accepts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one beat; push its expected result once the DUT takes it.
  task automatic send(input logic [DW-1:0] s, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] c,
                      input logic [DW-1:0] ed, input logic eb);
    logic acc;
    int   n;
    exp_t e;
    n = 0;
    in_vld = 1'b1;
    sum = s; in_a = a; in_b = b; in_c = c;
    forever begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_vld = 1'b0;
    if (acc) begin
      e.d = ed;
      e.b = eb;
      sb.push_back(e);
      accepts++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  // Monitor: compares every output handshake, tracks stall stability and uf_cnt.
  initial begin : monitor
    logic [UW-1:0] exp_uf;
    logic          stalled;
    logic [DW-1:0] held_d;
    logic          held_b;
    logic          hs_b;
    exp_t          e;
    exp_uf  = '0;
    stalled = 1'b0;
    held_d  = '0;
    held_b  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_uf  = '0;
        stalled = 1'b0;
        continue;
      end
      chk("uf_cnt_track", uf_cnt, exp_uf);
      if (stalled && out_vld) begin
        chk("stall_diff_hold", diff, held_d);
        chk("stall_borrow_hold", borrow, held_b);
      end
      hs_b = 1'b0;
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_diff", diff, e.d);
          chk("sb_borrow", borrow, e.b);
          hs_b = e.b;
        end
      end
      if (uf_clr) exp_uf = '0;
      else if (hs_b && exp_uf != UW'((1 << UW) - 1)) exp_uf = exp_uf + 1'b1;
      stalled = out_vld && !out_rdy;
      held_d  = diff;
      held_b  = borrow;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    #2;
    chk("rst_out_vld", out_vld, 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_borrow", borrow, 32'd0);
    chk("rst_uf_cnt", uf_cnt, 32'd0);
    chk("rst_in_rdy", in_rdy, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic recovery with two-edge latency
    send(8'h64, 8'h10, 8'h20, 8'h30, 8'h04, 1'b0);
    chk("t1_not_yet_valid", out_vld, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_out_vld", out_vld, 32'd1);
    chk("t1_diff", diff, 32'h04);
    chk("t1_borrow", borrow, 32'd0);
    drain();
    chk("t1_uf_cnt", uf_cnt, 32'd0);

    // 2: borrow; 3: partial wider than DSIZE
    send(8'h05, 8'h01, 8'h02, 8'h03, 8'hFF, 1'b1);
    drain();
    chk("t2_uf_cnt", uf_cnt, 32'd1);
    send(8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1);
    drain();
    chk("t3_uf_cnt", uf_cnt, 32'd2);

    // 4: backpressure with four back-to-back beats
    accepts = 0;
    out_rdy = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          send(8'(16 + k), 8'd5, 8'd5, 8'd6, 8'(k), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("t4_in_rdy_low", in_rdy, 32'd0);
        chk("t4_accepts", accepts, 32'd2);
        chk("t4_out_vld", out_vld, 32'd1);
        chk("t4_diff_stall", diff, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        chk("t4_diff_still", diff, 32'd1);
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
    join
    drain();
    chk("t4_total_accepts", accepts, 32'd4);

    // 5: saturation then clear racing an increment
    uf_clr = 1'b1;
    @(posedge clk);
    #1;
    uf_clr = 1'b0;
    chk("t5_cleared", uf_cnt, 32'd0);
    for (int k = 0; k < 17; k++)
      send(8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 1'b1);
    drain();
    chk("t5_saturated", uf_cnt, 32'd15);
    send(8'h00, 8'h02, 8'h00, 8'h00, 8'hFE, 1'b1);
    for (int n = 0; n < 10 && !out_vld; n++) begin
      @(posedge clk);
      #1;
    end
    chk("t5_18th_valid", out_vld, 32'd1);
    uf_clr = 1'b1;
    @(posedge clk);
    #1;
    uf_clr = 1'b0;
    chk("t5_clr_priority", uf_cnt, 32'd0);
    drain();

    // 6: reset with two beats in flight
    out_rdy = 1'b0;
    send(8'h30, 8'h01, 8'h02, 8'h03, 8'h2A, 1'b0);
    send(8'h31, 8'h01, 8'h02, 8'h03, 8'h2B, 1'b0);
    chk("t6_pre_vld", out_vld, 32'd1);
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_vld", out_vld, 32'd0);
    chk("t6_rst_diff", diff, 32'd0);
    chk("t6_rst_borrow", borrow, 32'd0);
    chk("t6_rst_in_rdy", in_rdy, 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_stale", out_vld, 32'd0);
    chk("t6_uf_cnt", uf_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
